// File: rtl/crc_stream_checker_if.sv
// Symbol-in / result-out bundle for crc_stream_checker.
//   sym_valid/sym_ready/sym_data : demapped symbol stream, MSB is the earlier bit
//   flush                        : drop the partially received frame
//   out_valid/out_ready          : frame result handshake
//   data_out/crc_ok              : frame data field (all ones on failure) and check flag
//   ok_cnt/err_cnt               : saturating pass/fail statistics
// slave is the checker side, master is the symbol source / result sink side.
interface crc_stream_checker_if #(
    parameter int K     = 8,
    parameter int SYM_W = 2,
    parameter int CNT_W = 16
);
    logic             sym_valid;
    logic             sym_ready;
    logic [SYM_W-1:0] sym_data;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [K-1:0]     data_out;
    logic             crc_ok;
    logic [CNT_W-1:0] ok_cnt;
    logic [CNT_W-1:0] err_cnt;

    modport slave (
        input  sym_valid, sym_data, flush, out_ready,
        output sym_ready, out_valid, data_out, crc_ok, ok_cnt, err_cnt
    );

    modport master (
        output sym_valid, sym_data, flush, out_ready,
        input  sym_ready, out_valid, data_out, crc_ok, ok_cnt, err_cnt
    );
endinterface

// File: rtl/crc_stream_checker.sv
// Streaming CRC codeword checker. Symbols of SYM_W bits are divided bit-serially
// by POLY as they arrive; after K+CRC_W bits the result (data field or all ones,
// plus crc_ok) is held on the output handshake until the sink takes it.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : crc_stream_checker_if.slave (symbol input, result output, statistics)
// The interface parameters K, SYM_W and CNT_W must match this module's.
// (K+CRC_W) must be a multiple of SYM_W.
//
// state   | meaning
// --------+-------------------------------------------------------------
// COLLECT | sym_ready=1, accepting symbols of the current frame
// HOLD    | result pending on out_valid, no symbols accepted
module crc_stream_checker #(
    parameter int               K     = 8,
    parameter int               CRC_W = 8,
    parameter logic [CRC_W-1:0] POLY  = 8'h07,
    parameter logic [CRC_W-1:0] INIT  = '0,
    parameter int               SYM_W = 2,
    parameter int               CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    crc_stream_checker_if.slave bus
);
    localparam int N  = K + CRC_W;
    localparam int CW = $clog2(N + 1);

    typedef enum logic {COLLECT, HOLD} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [CRC_W-1:0] r_q, r_d;
    logic [N-1:0]     buf_q, buf_d;
    logic             out_valid_q, out_valid_d;
    logic [K-1:0]     data_out_q, data_out_d;
    logic             crc_ok_q, crc_ok_d;
    logic [CNT_W-1:0] ok_cnt_q, ok_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic [CRC_W-1:0] r_step;
    logic [N-1:0]     buf_next;
    logic             last_sym;
    logic             pass;

    // All SYM_W division steps of the current symbol, MSB first.
    always_comb begin
        r_step = r_q;
        for (int i = SYM_W - 1; i >= 0; i--) begin
            r_step = {r_step[CRC_W-2:0], bus.sym_data[i]} ^
                     (r_step[CRC_W-1] ? POLY : '0);
        end
    end

    assign buf_next = {buf_q[N-SYM_W-1:0], bus.sym_data};
    assign last_sym = (bit_cnt_q == CW'(N - SYM_W));
    assign pass     = (r_step == '0);

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        r_d         = r_q;
        buf_d       = buf_q;
        out_valid_d = out_valid_q;
        data_out_d  = data_out_q;
        crc_ok_d    = crc_ok_q;
        ok_cnt_d    = ok_cnt_q;
        err_cnt_d   = err_cnt_q;
        case (state_q)
            COLLECT: begin
                // flush has priority over a symbol presented in the same cycle
                if (bus.flush) begin
                    bit_cnt_d = '0;
                    r_d       = INIT;
                end else if (bus.sym_valid) begin
                    buf_d = buf_next;
                    if (last_sym) begin
                        bit_cnt_d   = '0;
                        r_d         = INIT;
                        crc_ok_d    = pass;
                        data_out_d  = pass ? buf_next[N-1:CRC_W] : '1;
                        out_valid_d = 1'b1;
                        state_d     = HOLD;
                        if (pass) begin
                            if (ok_cnt_q != '1) ok_cnt_d = ok_cnt_q + 1'b1;
                        end else begin
                            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + CW'(SYM_W);
                        r_d       = r_step;
                    end
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= COLLECT;
            bit_cnt_q   <= '0;
            r_q         <= INIT;
            buf_q       <= '0;
            out_valid_q <= 1'b0;
            data_out_q  <= '0;
            crc_ok_q    <= 1'b0;
            ok_cnt_q    <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            r_q         <= r_d;
            buf_q       <= buf_d;
            out_valid_q <= out_valid_d;
            data_out_q  <= data_out_d;
            crc_ok_q    <= crc_ok_d;
            ok_cnt_q    <= ok_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign bus.sym_ready = (state_q == COLLECT);
    assign bus.out_valid = out_valid_q;
    assign bus.data_out  = data_out_q;
    assign bus.crc_ok    = crc_ok_q;
    assign bus.ok_cnt    = ok_cnt_q;
    assign bus.err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_crc_stream_checker.sv
// Bench for crc_stream_checker: default instance plus a CNT_W=2 instance sharing
// the same stimulus, table vectors, hand sequences and random frames against a
// long-division reference model.
module tb_crc_stream_checker;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sym_valid = 1'b0;
    logic [1:0] sym_data = 2'b00;
    logic       flush = 1'b0;
    logic       out_ready = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    int exp_ok = 0;
    int exp_err = 0;

    always #5 clk = ~clk;

    crc_stream_checker_if #(.K(8), .SYM_W(2), .CNT_W(16)) bus ();
    crc_stream_checker_if #(.K(8), .SYM_W(2), .CNT_W(2))  bus_s ();

    assign bus.sym_valid   = sym_valid;
    assign bus.sym_data    = sym_data;
    assign bus.flush       = flush;
    assign bus.out_ready   = out_ready;
    assign bus_s.sym_valid = sym_valid;
    assign bus_s.sym_data  = sym_data;
    assign bus_s.flush     = flush;
    assign bus_s.out_ready = out_ready;

    crc_stream_checker #(.K(8), .CRC_W(8), .POLY(8'h07), .INIT(8'h00),
                         .SYM_W(2), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .bus(bus));

    crc_stream_checker #(.K(8), .CRC_W(8), .POLY(8'h07), .INIT(8'h00),
                         .SYM_W(2), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .bus(bus_s));

    typedef struct {
        logic [15:0] cw;
        logic        ok;
        logic [7:0]  data;
    } vec_t;

    // Remainder of cw(x) divided by x^8+x^2+x+1, by plain long division.
    function automatic logic [7:0] rem_of(input logic [15:0] cw);
        logic [31:0] v;
        v = {16'h0, cw};
        for (int i = 15; i >= 8; i--)
            if (v[i]) v = v ^ (32'h107 << (i - 8));
        return v[7:0];
    endfunction

    function automatic int sat3(input int x);
        return (x > 3) ? 3 : x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_sym(input logic [1:0] s);
        int t;
        sym_valid = 1'b1;
        sym_data  = s;
        t = 0;
        while (!bus.sym_ready && t < 50) begin
            tick();
            t++;
        end
        check("sym_ready_before_accept", {31'b0, bus.sym_ready}, 32'd1);
        tick();
        sym_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] cw, input int gap_max);
        logic [1:0] s;
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, gap_max)) tick();
            s = cw[15 - 2*i -: 2];
            send_sym(s);
            if (i < 7) check("out_valid_mid_frame", {31'b0, bus.out_valid}, 32'd0);
        end
        check("out_valid_latency", {31'b0, bus.out_valid}, 32'd1);
    endtask

    task automatic collect(input logic ok, input logic [7:0] data, input int hold);
        if (ok) exp_ok++; else exp_err++;
        check("crc_ok", {31'b0, bus.crc_ok}, {31'b0, ok});
        check("data_out", {24'b0, bus.data_out}, {24'b0, data});
        check("ok_cnt", {16'b0, bus.ok_cnt}, exp_ok);
        check("err_cnt", {16'b0, bus.err_cnt}, exp_err);
        check("sat_ok_cnt", {30'b0, bus_s.ok_cnt}, sat3(exp_ok));
        check("sat_err_cnt", {30'b0, bus_s.err_cnt}, sat3(exp_err));
        for (int h = 0; h < hold; h++) begin
            tick();
            check("hold_sym_ready", {31'b0, bus.sym_ready}, 32'd0);
            check("hold_out_valid", {31'b0, bus.out_valid}, 32'd1);
            check("hold_data_out", {24'b0, bus.data_out}, {24'b0, data});
            check("hold_crc_ok", {31'b0, bus.crc_ok}, {31'b0, ok});
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("out_valid_after_ack", {31'b0, bus.out_valid}, 32'd0);
        check("sym_ready_after_ack", {31'b0, bus.sym_ready}, 32'd1);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_out_valid"}, {31'b0, bus.out_valid}, 32'd0);
        check({tag, "_ok_cnt"}, {16'b0, bus.ok_cnt}, 32'd0);
        check({tag, "_err_cnt"}, {16'b0, bus.err_cnt}, 32'd0);
        check({tag, "_sat_err_cnt"}, {30'b0, bus_s.err_cnt}, 32'd0);
        check({tag, "_sym_ready"}, {31'b0, bus.sym_ready}, 32'd1);
    endtask

    task automatic pulse_reset(input string tag);
        sym_valid = 1'b0;
        rst = 1'b1;
        #2;
        check_reset_state(tag);
        exp_ok  = 0;
        exp_err = 0;
        #1;
        rst = 1'b0;
        tick();
    endtask

    initial begin
        vec_t        vecs[6];
        logic [15:0] cw;
        logic [7:0]  d;
        logic [7:0]  r;

        vecs[0] = '{16'h0107, 1'b1, 8'h01};
        vecs[1] = '{16'h0106, 1'b0, 8'hFF};
        vecs[2] = '{16'hFFF3, 1'b1, 8'hFF};
        vecs[3] = '{16'h0000, 1'b1, 8'h00};
        vecs[4] = '{16'h0207, 1'b0, 8'hFF};
        vecs[5] = '{16'h8089, 1'b1, 8'h80};

        #2;
        check_reset_state("reset");
        check("reset_data_out", {24'b0, bus.data_out}, 32'd0);
        check("reset_crc_ok", {31'b0, bus.crc_ok}, 32'd0);
        #1;
        rst = 1'b0;
        tick();

        // table vectors, back-to-back symbols
        for (int v = 0; v < 6; v++) begin
            send_frame(vecs[v].cw, 0);
            collect(vecs[v].ok, vecs[v].data, 0);
        end

        // back-pressure: sym_valid kept high while the result is held
        send_frame(16'hFFF3, 0);
        sym_valid = 1'b1;
        sym_data  = 2'b00;
        collect(1'b1, 8'hFF, 5);
        send_frame(16'h0000, 0);
        collect(1'b1, 8'h00, 0);

        // flush with a 4th symbol presented in the same cycle
        send_sym(2'b00);
        send_sym(2'b00);
        send_sym(2'b00);
        sym_valid = 1'b1;
        sym_data  = 2'b01;
        flush     = 1'b1;
        tick();
        flush     = 1'b0;
        sym_valid = 1'b0;
        check("flush_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("flush_ok_cnt", {16'b0, bus.ok_cnt}, exp_ok);
        check("flush_err_cnt", {16'b0, bus.err_cnt}, exp_err);
        send_frame(16'h0107, 0);
        collect(1'b1, 8'h01, 0);

        // flush in HOLD is ignored
        send_frame(16'h0106, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("hold_flush_out_valid", {31'b0, bus.out_valid}, 32'd1);
        collect(1'b0, 8'hFF, 1);

        // async reset mid-frame, then in HOLD
        send_sym(2'b11);
        send_sym(2'b11);
        send_sym(2'b11);
        pulse_reset("rst_mid");
        send_frame(16'hFFF3, 0);
        collect(1'b1, 8'hFF, 0);
        send_frame(16'h0106, 0);
        pulse_reset("rst_hold");
        send_frame(16'hFFF3, 0);
        collect(1'b1, 8'hFF, 0);

        // saturation of the CNT_W=2 instance
        pulse_reset("rst_sat");
        for (int f = 0; f < 5; f++) begin
            send_frame(16'h0106, 0);
            collect(1'b0, 8'hFF, 0);
        end
        check("sat_err_stop", {30'b0, bus_s.err_cnt}, 32'd3);
        check("main_err_five", {16'b0, bus.err_cnt}, 32'd5);

        // random frames with idle gaps and random sink delay
        for (int f = 0; f < 40; f++) begin
            d = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 1)
                cw = {d, rem_of({d, 8'h00})};
            else
                cw = 16'($urandom_range(0, 65535));
            r = rem_of(cw);
            send_frame(cw, 2);
            collect(r == 8'h00, (r == 8'h00) ? cw[15:8] : 8'hFF, $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/crc_stream_checker.md
Name: crc_stream_checker

Overview:
- Streaming, parametrised successor of the team's combinational 16-bit CRC-8 codeword checker.
- Accepts a codeword serially as SYM_W-bit demodulated symbols (2 bits per 4FSK symbol by default) and runs a bit-serial polynomial division while symbols arrive.
- Presents each frame's data field plus a pass/fail flag on a valid/ready output, and keeps saturating pass/fail statistics.
- Sits between the 4FSK symbol demapper and the payload sink.

Parameters:
- K, 8, data field width in bits.
- CRC_W, 8, CRC field width in bits.
- POLY, 8'h07, generator polynomial, CRC_W bits, implicit leading 1 omitted.
- INIT, 0, initial remainder register value loaded at frame start.
- SYM_W, 2, bits per input symbol; (K+CRC_W) % SYM_W must be 0.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- sym_valid  in  1  input symbol valid.
- sym_ready  out  1  checker can accept a symbol.
- sym_data  in  SYM_W  symbol bits, MSB is the earlier codeword bit.
- flush  in  1  discard the partially received frame.
- out_valid  out  1  frame result valid.
- out_ready  in  1  sink accepts the result.
- data_out  out  K  data field if CRC passes, else all ones.
- crc_ok  out  1  remainder was zero.
- ok_cnt  out  CNT_W  frames passed, saturating.
- err_cnt  out  CNT_W  frames failed, saturating.

Behaviour:
- Reset (async, rst=1):
  - state=COLLECT, bit count=0, remainder r=INIT, shift buffer=0.
  - out_valid=0, data_out=0, crc_ok=0, ok_cnt=0, err_cnt=0.
- Frame: N=K+CRC_W bits, MSB first: data[K-1:0] then crc[CRC_W-1:0]. Frame length is NSYM=N/SYM_W symbols.
- States:
  - COLLECT: sym_ready=1. A symbol is accepted when sym_valid=1.
  - HOLD: sym_ready=0; out_valid=1.
- Per accepted symbol, process bits in order sym_data[SYM_W-1] down to sym_data[0]. For each bit b:
  - m = r[CRC_W-1]
  - r = {r[CRC_W-2:0], b} ^ (m ? POLY : 0)
  - Apply all SYM_W steps combinationally within one cycle.
- Shift buffer captures all N codeword bits.
- When the accepted symbol is the NSYM-th symbol, on the next edge:
  - Register the final remainder, crc_ok=(r_final==0) and data_out=crc_ok ? codeword[N-1:CRC_W] : all ones.
  - Set out_valid=1 and go to HOLD.
  - Increment ok_cnt or err_cnt, unless already all ones.
  - Reset bit count to 0 and r to INIT.
- Latency: out_valid rises 1 cycle after the last symbol is accepted.
- HOLD:
  - Outputs stay stable until out_ready=1.
  - On that edge, out_valid=0 and state returns to COLLECT.
  - Minimum frame period is NSYM+1 cycles.
- Result drop: none. The next frame is not accepted while a result is pending.
- flush:
  - In COLLECT: on the next edge, count=0 and r=INIT. A symbol presented in the same cycle is dropped (flush wins), and counters are unchanged.
  - In HOLD: ignored; the pending result is preserved.
- Counter saturation: a counter at 2^CNT_W-1 holds its value.
- Mid-frame reset: partial frame lost; the first symbol after reset release starts a new frame.
- sym_data is ignored whenever sym_valid=0 or sym_ready=0.

Test Plan:
- Pass frame: defaults, send symbols 0,0,0,1,0,0,1,3 (codeword 0x0107), out_ready=1. Required: out_valid one cycle after the 8th symbol, crc_ok=1, data_out=0x01, ok_cnt=1.
- Corrupted frame: send codeword 0x0106 (symbols 0,0,0,1,0,0,1,2). Required: crc_ok=0, data_out=0xFF, err_cnt=1, ok_cnt unchanged.
- Back-pressure: send codeword 0xFFF3 with out_ready=0 for 5 cycles while sym_valid stays 1. Required: sym_ready=0 throughout HOLD and result held at data_out=0xFF, crc_ok=1. When out_ready=1, the next frame 0x0000 is accepted and yields data_out=0x00, crc_ok=1.
- Flush: send 3 symbols of 0x0107, assert flush together with a 4th symbol, then send the full 0x0107. Required: exactly one result (data_out=0x01, crc_ok=1); counters change by 1 only.
- Async reset: assert rst mid-frame and in HOLD. Required: out_valid=0 and counters=0 immediately (no clock needed), then a clean frame 0xFFF3 passes.
- Saturation: CNT_W=2, send 5 corrupted frames. Required: err_cnt stops at 3.
